// File: rtl/bz_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// bz_deserializer_pkg
// Shared constants and types for the flit deserializer.
//   FLIT_W   : width of one flit from the FIFO (tail bit + 10 data bits)
//   TAIL_BIT : index of the tail flag inside a flit
//   WORD_W   : width of the reassembled output word {route, code, payload}
//   ERR_W    : width of the saturating malformed-flit counter
//   state_e  : assembly FSM states (header, data flits 1..3)
// -----------------------------------------------------------------------------
package bz_deserializer_pkg;

    localparam int FLIT_W   = 11;
    localparam int TAIL_BIT = 10;
    localparam int WORD_W   = 35;
    localparam int ERR_W    = 8;

    typedef enum logic [1:0] {
        HDR = 2'd0,
        D1  = 2'd1,
        D2  = 2'd2,
        D3  = 2'd3
    } state_e;

endpackage

// File: rtl/bz_deserializer.sv
// -----------------------------------------------------------------------------
// bz_deserializer
// Reassembles 4-flit packets (header, code, payload-high, payload-low) read from
// a show-ahead FIFO into 35-bit words presented on a valid/accept channel.
// A tail=0 flit in D3 keeps the stored route and jumps straight to D1, so
// back-to-back packets may omit their header flit.
//
// Ports
//   clk               : clock
//   reset             : asynchronous active-low reset
//   data_in[10:0]     : FIFO head flit, bit 10 = tail, bits 9:0 = data
//   empty             : FIFO empty
//   rdreq             : FIFO pop (combinational)
//   PC_out_channel_d  : output word {route[7:0], code[6:0], payload[19:0]}
//   PC_out_channel_v  : output word valid
//   PC_out_channel_a  : output word accept from the consumer
//   err_count[7:0]    : saturating count of malformed (early-tail) flits
// -----------------------------------------------------------------------------
module bz_deserializer
    import bz_deserializer_pkg::*;
#(
    parameter int NPCroute = 8,
    parameter int NPCcode  = 7,
    parameter int NPCdata  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] data_in,
    input  logic              empty,
    output logic              rdreq,
    output logic [WORD_W-1:0] PC_out_channel_d,
    output logic              PC_out_channel_v,
    input  logic              PC_out_channel_a,
    output logic [ERR_W-1:0]  err_count
);

    localparam int HALF_W = NPCdata / 2;

    state_e              state_q,   state_d;
    logic [NPCroute-1:0] route_q,   route_d;
    logic [NPCcode-1:0]  code_q,    code_d;
    logic [NPCdata-1:0]  payload_q, payload_d;
    logic [WORD_W-1:0]   out_q,     out_d;
    logic                out_v_q,   out_v_d;
    logic [ERR_W-1:0]    err_q,     err_d;

    logic                tail;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
        return (x == {ERR_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    assign tail = data_in[TAIL_BIT];

    // The only stall point is D3 with the holding register still occupied and
    // not being drained this cycle; earlier flits keep flowing underneath it.
    assign rdreq = reset & ~empty &
                   ~((state_q == D3) & out_v_q & ~PC_out_channel_a);

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        code_d    = code_q;
        payload_d = payload_q;
        out_d     = out_q;
        out_v_d   = out_v_q;
        err_d     = err_q;

        // Drain first; a D3 pop below may refill in the same cycle.
        if (out_v_q && PC_out_channel_a) begin
            out_v_d = 1'b0;
        end

        if (rdreq) begin
            unique case (state_q)
                HDR: begin
                    if (tail) begin
                        err_d = sat_inc(err_q);
                    end else begin
                        route_d = data_in[NPCroute-1:0];
                        state_d = D1;
                    end
                end
                D1: begin
                    if (tail) begin
                        err_d   = sat_inc(err_q);
                        state_d = HDR;
                    end else begin
                        code_d  = data_in[NPCcode-1:0];
                        state_d = D2;
                    end
                end
                D2: begin
                    if (tail) begin
                        err_d   = sat_inc(err_q);
                        state_d = HDR;
                    end else begin
                        payload_d[NPCdata-1:HALF_W] = data_in[HALF_W-1:0];
                        state_d = D3;
                    end
                end
                D3: begin
                    payload_d[HALF_W-1:0] = data_in[HALF_W-1:0];
                    out_d   = {route_q, code_q, payload_q[NPCdata-1:HALF_W],
                               data_in[HALF_W-1:0]};
                    out_v_d = 1'b1;
                    state_d = tail ? HDR : D1;
                end
                default: state_d = HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HDR;
            route_q   <= '0;
            code_q    <= '0;
            payload_q <= '0;
            out_q     <= '0;
            out_v_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            route_q   <= route_d;
            code_q    <= code_d;
            payload_q <= payload_d;
            out_q     <= out_d;
            out_v_q   <= out_v_d;
            err_q     <= err_d;
        end
    end

    assign PC_out_channel_d = out_q;
    assign PC_out_channel_v = out_v_q;
    assign err_count        = err_q;

endmodule

// File: tb/tb_bz_deserializer.sv
module tb_bz_deserializer;

    logic        clk;
    logic        reset;
    logic [10:0] data_in;
    logic        empty;
    logic        rdreq;
    logic [34:0] d;
    logic        v;
    logic        a;
    logic [7:0]  err_count;

    bz_deserializer dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .empty            (empty),
        .rdreq            (rdreq),
        .PC_out_channel_d (d),
        .PC_out_channel_v (v),
        .PC_out_channel_a (a),
        .err_count        (err_count)
    );

    localparam logic [34:0] W1 = {8'h15, 7'h2A, 20'hABCDE};
    localparam logic [34:0] W2 = {8'h15, 7'h01, 20'h00003};
    localparam logic [34:0] W3 = {8'hC3, 7'h01, 20'h00003};

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    logic [10:0] q[$];
    logic [34:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Show-ahead FIFO model: pop decided on the edge, head re-driven shortly after.
    initial begin
        data_in = '0;
        empty   = 1'b1;
    end
    always @(posedge clk) begin
        logic pop;
        pop = rdreq;
        #2;
        if (pop && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
        end
        empty   = (q.size() == 0);
        data_in = (q.size() > 0) ? q[0] : 11'h000;
    end

    // Monitor / scoreboard
    logic        hold;
    logic [34:0] hold_d;
    initial hold = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            hold = 1'b0;
        end else begin
            if (hold && v) check("d_stable", {29'd0, d}, {29'd0, hold_d});
            if (v && a) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", d);
                end else begin
                    logic [34:0] e;
                    e = sb.pop_front();
                    check("word", {29'd0, d}, {29'd0, e});
                end
            end
            hold   = v && !a;
            hold_d = d;
        end
    end

    task automatic push_pkt(input logic [10:0] f0, input logic [10:0] f1,
                            input logic [10:0] f2, input logic [10:0] f3);
        @(posedge clk);
        #1;
        q.push_back(f0);
        q.push_back(f1);
        q.push_back(f2);
        q.push_back(f3);
    endtask

    task automatic wait_pops(input int n);
        int t = 0;
        while (pops < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (pops < n) begin
            tests++;
            fails++;
            $display("FAIL wait_pops_timeout: got %0d expected %0d", pops, n);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (q.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got %0d flits left expected 0", q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        a     = 1'b1;

        // Reset state, with a flit waiting in the FIFO
        q.push_back(11'h015);
        repeat (3) @(negedge clk);
        check("rst_rdreq", {63'd0, rdreq}, 64'd0);
        check("rst_v", {63'd0, v}, 64'd0);
        check("rst_d", {29'd0, d}, 64'd0);
        check("rst_err", {56'd0, err_count}, 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single packet with latency check
        base = pops;
        sb.push_back(W1);
        push_pkt(11'h015, 11'h02A, 11'h2AF, 11'h4DE);
        wait_pops(base + 3);
        check("lat_v_before", {63'd0, v}, 64'd0);
        @(negedge clk);
        check("lat_pops", pops, base + 4);
        check("lat_v_after", {63'd0, v}, 64'd1);
        wait_idle();
        check("single_err", {56'd0, err_count}, 64'd0);

        // Header elision
        sb.push_back(W1);
        sb.push_back(W2);
        @(posedge clk);
        #1;
        q.push_back(11'h015); q.push_back(11'h02A); q.push_back(11'h2AF);
        q.push_back(11'h0DE); q.push_back(11'h001); q.push_back(11'h000);
        q.push_back(11'h403);
        wait_idle();
        check("elide_sb_empty", sb.size(), 0);

        // Backpressure
        @(posedge clk);
        #1;
        a = 1'b0;
        sb.push_back(W1);
        sb.push_back(W3);
        push_pkt(11'h015, 11'h02A, 11'h2AF, 11'h4DE);
        push_pkt(11'h0C3, 11'h001, 11'h000, 11'h403);
        repeat (20) @(negedge clk);
        check("bp_fifo_left", q.size(), 1);
        check("bp_rdreq", {63'd0, rdreq}, 64'd0);
        check("bp_v", {63'd0, v}, 64'd1);
        check("bp_d_first", {29'd0, d}, {29'd0, W1});
        @(posedge clk);
        #1;
        a = 1'b1;
        @(negedge clk);
        check("bp_v_first", {63'd0, v}, 64'd1);
        @(negedge clk);
        check("bp_no_bubble", {63'd0, v}, 64'd1);
        check("bp_d_second", {29'd0, d}, {29'd0, W3});
        wait_idle();
        check("bp_sb_empty", sb.size(), 0);

        // Malformed flits
        @(posedge clk);
        #1;
        q.push_back(11'h415);
        wait_idle();
        check("mal_hdr_err", {56'd0, err_count}, 64'd1);
        @(posedge clk);
        #1;
        q.push_back(11'h015);
        q.push_back(11'h42A);
        wait_idle();
        check("mal_trunc_err", {56'd0, err_count}, 64'd2);
        check("mal_no_word", {63'd0, v}, 64'd0);
        sb.push_back(W1);
        push_pkt(11'h015, 11'h02A, 11'h2AF, 11'h4DE);
        wait_idle();
        check("mal_good_err", {56'd0, err_count}, 64'd2);
        check("mal_sb_empty", sb.size(), 0);

        // Reset mid-packet with a pending output word
        @(posedge clk);
        #1;
        a = 1'b0;
        sb.push_back(W1);
        push_pkt(11'h015, 11'h02A, 11'h2AF, 11'h4DE);
        wait_idle();
        check("mr_pending_v", {63'd0, v}, 64'd1);
        base = pops;
        @(posedge clk);
        #1;
        q.push_back(11'h015);
        q.push_back(11'h02A);
        wait_pops(base + 2);
        reset = 1'b0;
        sb.delete();
        q.delete();
        #1;
        check("mr_v", {63'd0, v}, 64'd0);
        check("mr_d", {29'd0, d}, 64'd0);
        check("mr_err", {56'd0, err_count}, 64'd0);
        a = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.push_back(W1);
        push_pkt(11'h015, 11'h02A, 11'h2AF, 11'h4DE);
        wait_idle();
        check("mr_after_err", {56'd0, err_count}, 64'd0);
        check("mr_sb_empty", sb.size(), 0);

        // Saturation
        @(posedge clk);
        #1;
        for (int i = 0; i < 255; i++) q.push_back(11'h400);
        wait_idle();
        check("sat_255", {56'd0, err_count}, 64'hFF);
        @(posedge clk);
        #1;
        for (int i = 0; i < 45; i++) q.push_back(11'h400);
        wait_idle();
        check("sat_300", {56'd0, err_count}, 64'hFF);
        check("sat_no_word", {63'd0, v}, 64'd0);

        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
